// File: rtl/pio_sm_sequencer.sv
// rtl/pio_sm_sequencer.sv - PIO state-machine sequencer: pc, fractional clock divider, delay counter, side-set latch
module pio_sm_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        restart,
  input  logic [15:0] div_int,
  input  logic [7:0]  div_frac,
  input  logic [4:0]  wrap_target,
  input  logic [4:0]  wrap_top,
  input  logic [4:0]  delay,
  input  logic [4:0]  side_set,
  input  logic        sideset_enabled,
  input  logic        stall,
  input  logic        jmp,
  input  logic [4:0]  jmp_addr,
  output logic        exec_en,
  output logic [4:0]  pc,
  output logic [4:0]  sideset_out,
  output logic        sideset_valid,
  output logic        delaying
);

  typedef enum logic {EXEC = 1'b0, DELAY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [7:0]  acc_q, acc_d;
  logic [4:0]  dcnt_q, dcnt_d;
  logic [4:0]  pc_q, pc_d;
  logic [4:0]  ss_q, ss_d;
  logic        ssv_q, ssv_d;
  logic        tick;
  logic [8:0]  frac_sum;
  logic [16:0] div_m1;

  assign tick          = en && (cnt_q == 17'd0);
  assign exec_en       = tick && (state_q == EXEC);
  assign pc            = pc_q;
  assign sideset_out   = ss_q;
  assign sideset_valid = ssv_q;
  assign delaying      = (state_q == DELAY);

  // A zero integer divisor stands for 65536, so its reload value is 65535.
  assign div_m1   = (div_int == 16'd0) ? 17'd65535 : ({1'b0, div_int} - 17'd1);
  assign frac_sum = {1'b0, acc_q} + {1'b0, div_frac};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dcnt_d  = dcnt_q;
    pc_d    = pc_q;
    ss_d    = ss_q;
    ssv_d   = 1'b0;
    if (en) begin
      if (tick) begin
        cnt_d = div_m1 + {16'd0, frac_sum[8]};
        acc_d = frac_sum[7:0];
        case (state_q)
          EXEC: begin
            if (sideset_enabled) begin
              ss_d  = side_set;
              ssv_d = 1'b1;
            end
            if (!stall) begin
              if (jmp)                 pc_d = jmp_addr;
              else if (pc_q == wrap_top) pc_d = wrap_target;
              else                     pc_d = pc_q + 5'd1;
              if (delay != 5'd0) begin
                state_d = DELAY;
                dcnt_d  = delay;
              end
            end
          end
          DELAY: begin
            dcnt_d = dcnt_q - 5'd1;
            if (dcnt_q == 5'd1) state_d = EXEC;
          end
          default: state_d = EXEC;
        endcase
      end else begin
        cnt_d = cnt_q - 17'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EXEC;
      cnt_q   <= 17'd0;
      acc_q   <= 8'd0;
      dcnt_q  <= 5'd0;
      pc_q    <= 5'd0;
      ss_q    <= 5'd0;
      ssv_q   <= 1'b0;
    end else if (restart) begin
      // Side-set latch deliberately survives a restart.
      state_q <= EXEC;
      cnt_q   <= 17'd0;
      acc_q   <= 8'd0;
      dcnt_q  <= 5'd0;
      pc_q    <= wrap_target;
      ssv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dcnt_q  <= dcnt_d;
      pc_q    <= pc_d;
      ss_q    <= ss_d;
      ssv_q   <= ssv_d;
    end
  end

endmodule

// File: tb/tb_pio_sm_sequencer.sv
// tb/tb_pio_sm_sequencer.sv - scoreboard bench for pio_sm_sequencer
module tb_pio_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset, en, restart;
  logic [15:0] div_int;
  logic [7:0]  div_frac;
  logic [4:0]  wrap_target, wrap_top, delay, side_set, jmp_addr;
  logic        sideset_enabled, stall, jmp;
  logic        exec_en, sideset_valid, delaying;
  logic [4:0]  pc, sideset_out;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  pio_sm_sequencer dut (
    .clk(clk), .reset(reset), .en(en), .restart(restart),
    .div_int(div_int), .div_frac(div_frac),
    .wrap_target(wrap_target), .wrap_top(wrap_top),
    .delay(delay), .side_set(side_set), .sideset_enabled(sideset_enabled),
    .stall(stall), .jmp(jmp), .jmp_addr(jmp_addr),
    .exec_en(exec_en), .pc(pc), .sideset_out(sideset_out),
    .sideset_valid(sideset_valid), .delaying(delaying)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Packed view: {exec_en, delaying, sideset_valid, pc, sideset_out}
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [31:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, {19'd0, exec_en, delaying, sideset_valid, pc, sideset_out}, e);
    end
  end

  task automatic drive(input string tag, input logic e, input logic d, input logic v,
                       input logic [4:0] p, input logic [4:0] s);
    exp_q.push_back({19'd0, e, d, v, p, s});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; restart = 1'b0;
    div_int = 16'd1; div_frac = 8'd0;
    wrap_target = 5'd0; wrap_top = 5'd31;
    delay = 5'd0; side_set = 5'd0; sideset_enabled = 1'b0;
    stall = 1'b0; jmp = 1'b0; jmp_addr = 5'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] seq1[8];
    logic       ex2[13];
    logic [4:0] pc2[13];
    int         wait_n;

    // Reset state with en low
    do_reset();
    drive("reset_state", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);

    // Divider 1.0 with wrap 4 -> 2
    do_reset();
    en = 1'b1; wrap_target = 5'd2; wrap_top = 5'd4;
    seq1 = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd2, 5'd3, 5'd4};
    for (int i = 0; i < 8; i++) drive($sformatf("wrap%0d", i), 1'b1, 1'b0, 1'b0, seq1[i], 5'd0);

    // Divider 2.5
    do_reset();
    en = 1'b1; div_int = 16'd2; div_frac = 8'd128;
    ex2 = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1};
    pc2 = '{5'd0, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd3, 5'd3, 5'd4, 5'd4, 5'd4, 5'd5, 5'd5};
    for (int i = 0; i < 13; i++) drive($sformatf("div25_%0d", i), ex2[i], 1'b0, 1'b0, pc2[i], 5'd0);

    // Delay of 3
    do_reset();
    en = 1'b1; delay = 5'd3;
    drive("dly0", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    delay = 5'd0;
    for (int i = 1; i <= 3; i++) drive($sformatf("dly%0d", i), 1'b0, 1'b1, 1'b0, 5'd1, 5'd0);
    drive("dly4", 1'b1, 1'b0, 1'b0, 5'd1, 5'd0);
    drive("dly5", 1'b1, 1'b0, 1'b0, 5'd2, 5'd0);

    // Stall with side-set
    do_reset();
    en = 1'b1; stall = 1'b1; sideset_enabled = 1'b1; side_set = 5'h15;
    drive("stall0", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    drive("stall1", 1'b1, 1'b0, 1'b1, 5'd0, 5'h15);
    drive("stall2", 1'b1, 1'b0, 1'b1, 5'd0, 5'h15);
    stall = 1'b0; sideset_enabled = 1'b0;
    drive("stall3", 1'b1, 1'b0, 1'b1, 5'd0, 5'h15);
    drive("stall4", 1'b1, 1'b0, 1'b0, 5'd1, 5'h15);

    // Jump beats wrap, pc 31 rollover, en-low freeze
    do_reset();
    en = 1'b1; wrap_top = 5'd0; wrap_target = 5'd3; jmp = 1'b1; jmp_addr = 5'd9;
    drive("jmp0", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    jmp = 1'b0;
    drive("jmp1", 1'b1, 1'b0, 1'b0, 5'd9, 5'd0);
    jmp = 1'b1; jmp_addr = 5'd31;
    drive("jmp2", 1'b1, 1'b0, 1'b0, 5'd10, 5'd0);
    jmp = 1'b0; en = 1'b0;
    drive("freeze", 1'b0, 1'b0, 1'b0, 5'd31, 5'd0);
    en = 1'b1;
    drive("pc31", 1'b1, 1'b0, 1'b0, 5'd31, 5'd0);
    drive("roll0", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    drive("wrap_after_roll", 1'b1, 1'b0, 1'b0, 5'd3, 5'd0);

    // Restart mid-delay, then divider 0 = 65536
    do_reset();
    en = 1'b1; wrap_target = 5'd6; delay = 5'd3;
    drive("rs0", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    delay = 5'd0;
    drive("rs1", 1'b0, 1'b1, 1'b0, 5'd1, 5'd0);
    restart = 1'b1;
    drive("rs2", 1'b0, 1'b1, 1'b0, 5'd1, 5'd0);
    restart = 1'b0; div_int = 16'd0;
    drive("rs3", 1'b1, 1'b0, 1'b0, 5'd6, 5'd0);
    wait_n = 0;
    for (int n = 1; n <= 70000; n++) begin
      if (exec_en) begin
        wait_n = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_val("div0_period", wait_n, 32'd65536);
    check_val("div0_pc", {27'd0, pc}, 32'd7);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pio_sm_sequencer.md
# pio_sm_sequencer

Per-state-machine sequencer for the PIO core: owns the program counter, the fractional clock divider, the post-instruction delay counter and the side-set output latch. It sits between instruction memory and the instruction decoder. It consumes the decoder's `delay`, `side_set` and `sideset_enabled` fields plus stall/jump status from the execution units, and emits `pc` and a one-cycle execute strobe. One instance exists per state machine.

## Interface
Parameters: none. All widths are fixed by the 32-entry PIO instruction memory.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; one clock, sync reset active high
- `en`  in  1  state-machine enable; low freezes all state
- `restart`  in  1  one-cycle pulse; clears divider and delay, `pc` <- `wrap_target`
- `div_int`  in  16  divider integer part; 0 means 65536
- `div_frac`  in  8  divider fractional part, in units of 1/256
- `wrap_target`  in  5  wrap destination
- `wrap_top`  in  5  wrap source address
- `delay`  in  5  decoded delay cycles of the instruction at `pc`
- `side_set`  in  5  decoded side-set value
- `sideset_enabled`  in  1  side-set applies to this instruction
- `stall`  in  1  instruction at `pc` cannot complete this tick
- `jmp`  in  1  instruction at `pc` completes by jumping
- `jmp_addr`  in  5  jump destination
- `exec_en`  out  1  execute strobe; the instruction at `pc` is evaluated this cycle
- `pc`  out  5  current instruction address (registered)
- `sideset_out`  out  5  latched side-set value (registered)
- `sideset_valid`  out  1  one-cycle pulse, the cycle after `sideset_out` was updated
- `delaying`  out  1  high while in DELAY (registered)

## Operation
- Priority: `reset` > `restart` > `en` low > normal operation.
- Divider state: `cnt` (17 bit) and `acc` (8 bit).
  - `tick` = `en` & (`cnt` == 0).
  - On `tick`: {carry, `acc`} <- `acc` + `div_frac`; `cnt` <- ({1'b0,`div_int`} - 1 + carry) mod 2^17. For `div_int` = 0, `div_int` - 1 is taken as 65535.
  - Otherwise, when `en`: `cnt` <- `cnt` - 1.
  - Average tick period = `div_int` + `div_frac`/256 cycles. `div_int`=1, `div_frac`=0 ticks every cycle.
- States: EXEC, DELAY. A 5-bit delay counter `dcnt` is also held.
- EXEC:
  - `exec_en` = `tick` & (state == EXEC). This is combinational from registers and `en` only; there is no path from `stall`.
  - On `exec_en` with `sideset_enabled`: `sideset_out` <- `side_set` and `sideset_valid` pulses next cycle. This also happens on stalled ticks, so side-set asserts at the instruction's first tick.
  - On `exec_en` with `stall`: `pc` is held and the state stays EXEC. Delay does not start.
  - On `exec_en` with no `stall`, next `pc` is:
    - `jmp_addr` if `jmp` (wrap is ignored);
    - else `wrap_target` if `pc` == `wrap_top`;
    - else `pc`+1 mod 32.
  - On that same completing tick: if `delay` != 0, go to DELAY with `dcnt` <- `delay`; otherwise stay in EXEC.
- DELAY:
  - On `tick`: if `dcnt` == 1, go to EXEC; else `dcnt` <- `dcnt` - 1.
  - A delay of N therefore costs exactly N ticks.
- `restart`: `cnt` <- 0, `acc` <- 0, state <- EXEC, `dcnt` <- 0, `pc` <- `wrap_target`. `sideset_out` is unchanged. This applies mid-delay and mid-stall.
- `en` low: `cnt`, `acc`, `dcnt`, state and `pc` all hold. `exec_en` stays 0. `sideset_valid` returns to 0.

## Timing
- Reset values: `pc`=0, state=EXEC, `cnt`=0, `acc`=0, `dcnt`=0, `sideset_out`=0, `sideset_valid`=0, `delaying`=0.
- `exec_en` is therefore high on the first cycle with `en`=1 after reset.
- `pc`, `delaying` and `sideset_out` update at the clock edge ending an `exec_en`/`tick` cycle. They are visible the next cycle.
- Decoder inputs and `stall`/`jmp` must be valid in the `exec_en` cycle. They are sampled only then (`delay`, `jmp`) or at that edge.
- `wrap_top` == `wrap_target`: the same address repeats every completing tick.
- `pc`=31 with `wrap_top`!=31 advances to 0.

## Test plan
- Divider 1.0, `wrap_target`=2, `wrap_top`=4, start `pc`=0, no stall/delay -> `pc` sequence 0,1,2,3,4,2,3,4; `exec_en` high every cycle.
- Divider 2.5 (`div_int`=2, `div_frac`=128) from reset -> `exec_en` at cycles 0,2,5,7,10,12.
- Instruction at `pc` 0 with `delay`=3, divider 1.0 -> `exec_en` at cycle 0, `delaying` high for cycles 1-3, next `exec_en` at cycle 4 with `pc`=1.
- `stall` held for 3 `exec_en` cycles, `sideset_enabled`=1, `side_set`=5'h15 -> `pc` holds; `sideset_out`=5'h15 from cycle 1; `sideset_valid` pulses on each stalled tick; `pc` advances after `stall` drops.
- `jmp`=1, `jmp_addr`=9 with `pc`=`wrap_top` -> next `pc`=9, not `wrap_target`.
- `restart` during DELAY (`dcnt`=2) with `wrap_target`=6 -> next cycle `pc`=6, `delaying`=0, `exec_en`=1. Then `div_int`=0 -> next `exec_en` exactly 65536 cycles later.
